// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL acquisition/lock sequencer stepping loop-filter gain gears from per-ref-period error counts
module pll_lock_ctrl #(
  parameter int ERR_W        = 16,
  parameter int LOCK_THRESH  = 8,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int ACQ_MIN      = 32,
  parameter int REF_TO_W     = 20
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       ref_clk,
  input  logic [3:0] error_in,
  input  logic       error_valid,
  output logic [1:0] gear,
  output logic       filter_clr,
  output logic       locked,
  output logic       lol_pulse,
  output logic       ref_lost,
  output logic [2:0] state_out
);
  typedef enum logic [2:0] {IDLE = 3'd0, CLEAR = 3'd1, ACQUIRE = 3'd2, TRACK = 3'd3, LOCKED = 3'd4} state_t;
  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam int AW = $clog2(ACQ_MIN + 1);
  localparam logic [GW-1:0] LC = GW'(LOCK_COUNT);
  localparam logic [BW-1:0] UC = BW'(UNLOCK_COUNT);
  localparam logic [AW-1:0] AM = AW'(ACQ_MIN);
  localparam logic [ERR_W-1:0] TH = ERR_W'(LOCK_THRESH);
  state_t state, nxt;
  logic [2:0] sync;
  logic [ERR_W-1:0] err_cnt;
  logic [GW-1:0] good_run, gr_n;
  logic [BW-1:0] bad_run, br_n;
  logic [AW-1:0] acq_periods, ap_n;
  logic [REF_TO_W-1:0] ref_to;
  logic ref_rise, nz, active, to_hit, eval_p, good;
  assign state_out = state;
  // Run counters saturate at their thresholds, so "reaches" and ">=" coincide
  always_comb begin
    ref_rise = sync[2:1] == 2'b01;
    nz = error_valid && error_in != 4'd0;
    active = state inside {ACQUIRE, TRACK, LOCKED};
    to_hit = state != IDLE && &ref_to;
    eval_p = ref_rise && active && !ref_lost && !to_hit;
    good = err_cnt <= TH;
    gr_n = !good ? '0 : good_run == LC ? good_run : good_run + GW'(1);
    br_n = good ? '0 : bad_run == UC ? bad_run : bad_run + BW'(1);
    ap_n = acq_periods == AM ? acq_periods : acq_periods + AW'(1);
    nxt = state;
    if (!enable) nxt = IDLE;
    else case (state)
      IDLE:    nxt = CLEAR;
      CLEAR:   nxt = ACQUIRE;
      ACQUIRE: nxt = eval_p && ap_n == AM && gr_n == LC ? TRACK : ACQUIRE;
      TRACK:   nxt = to_hit || (eval_p && br_n == UC) ? ACQUIRE : eval_p && gr_n == LC ? LOCKED : TRACK;
      LOCKED:  nxt = to_hit || (eval_p && br_n == UC) ? ACQUIRE : LOCKED;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync        <= '0;
      state       <= IDLE;
      gear        <= '0;
      filter_clr  <= 1'b0;
      locked      <= 1'b0;
      lol_pulse   <= 1'b0;
      ref_lost    <= 1'b0;
      err_cnt     <= '0;
      good_run    <= '0;
      bad_run     <= '0;
      acq_periods <= '0;
      ref_to      <= '0;
    end else begin
      sync       <= {sync[1:0], ref_clk};
      state      <= nxt;
      gear       <= nxt == ACQUIRE ? 2'd3 : nxt == TRACK ? 2'd2 : nxt == LOCKED ? 2'd1 : 2'd0;
      filter_clr <= nxt == CLEAR;
      locked     <= nxt == LOCKED;
      lol_pulse  <= state == LOCKED && nxt == ACQUIRE;
      ref_lost   <= (enable && to_hit) || (ref_lost && !ref_rise);
      if (!enable || state == IDLE || state == CLEAR || to_hit) begin
        err_cnt     <= '0;
        good_run    <= '0;
        bad_run     <= '0;
        acq_periods <= '0;
        ref_to      <= '0;
      end else begin
        ref_to  <= ref_rise ? '0 : ref_to + REF_TO_W'(1);
        err_cnt <= ref_rise ? ERR_W'(nz) : err_cnt + ERR_W'(nz && !(&err_cnt));
        if (eval_p) begin
          good_run    <= nxt == state ? gr_n : '0;
          bad_run     <= nxt == state ? br_n : '0;
          acq_periods <= state == ACQUIRE ? ap_n : nxt == ACQUIRE ? '0 : acq_periods;
        end
      end
    end
  end
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: table-driven and randomized checks of pll_lock_ctrl against a per-period reference model
module tb_pll_lock_ctrl;
  logic sys_clk = 0, rst = 1, enable = 0, ref_clk = 0, error_valid = 0;
  logic [3:0] error_in = 0;
  logic [1:0] gear;
  logic filter_clr, locked, lol_pulse, ref_lost;
  logic [2:0] state_out;

  pll_lock_ctrl #(.REF_TO_W(10)) dut (
    .sys_clk(sys_clk), .rst(rst), .enable(enable), .ref_clk(ref_clk),
    .error_in(error_in), .error_valid(error_valid), .gear(gear),
    .filter_clr(filter_clr), .locked(locked), .lol_pulse(lol_pulse),
    .ref_lost(ref_lost), .state_out(state_out)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0, n_bad = 0, lol_cnt = 0, clr_cnt = 0;
  int m_st = 0, m_gr = 0, m_br = 0, m_ap = 0, m_lol = 0, m_clr = 0, pend = 0;
  bit m_lost = 0;
  int gmap [5] = '{0, 0, 3, 2, 1};

  typedef struct {int reps; int n; int len; int st; int lol;} row_t;
  row_t tbl [13];

  always @(negedge sys_clk) begin
    lol_cnt += int'(lol_pulse === 1'b1);
    clr_cnt += int'(filter_clr === 1'b1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string nm);
    #1;
    chk({nm, " state"}, state_out, m_st);
    chk({nm, " gear"}, gear, gmap[m_st]);
    chk({nm, " locked"}, locked, int'(m_st == 4));
    chk({nm, " ref_lost"}, ref_lost, int'(m_lost));
    chk({nm, " lol count"}, lol_cnt, m_lol);
    chk({nm, " clr count"}, clr_cnt, m_clr);
  endtask

  // Period-level model: one evaluation per reference rise, using the error count of the period just ended
  task automatic model_rise();
    bit g;
    if (m_lost) m_lost = 0;
    else if (m_st >= 2) begin
      g = pend <= 8;
      m_gr = g ? (m_gr < 16 ? m_gr + 1 : 16) : 0;
      m_br = g ? 0 : (m_br < 4 ? m_br + 1 : 4);
      if (m_st == 2) begin
        if (m_ap < 32) m_ap++;
        if (m_ap >= 32 && m_gr >= 16) begin m_st = 3; m_gr = 0; m_br = 0; end
      end else if (m_st == 3) begin
        if (m_gr >= 16) begin m_st = 4; m_gr = 0; m_br = 0; end
        else if (m_br >= 4) begin m_st = 2; m_ap = 0; m_gr = 0; m_br = 0; end
      end else if (m_br >= 4) begin
        m_st = 2; m_ap = 0; m_gr = 0; m_br = 0; m_lol++;
      end
    end
    pend = 0;
  endtask

  task automatic model_enable();
    m_st = 2; m_gr = 0; m_br = 0; m_ap = 0; pend = 0; m_clr++;
  endtask

  // One reference period of len cycles carrying n qualified non-zero errors plus unqualified decoys
  task automatic period(input int n, input int len);
    int left = n;
    @(negedge sys_clk) ref_clk = 1;
    model_rise();
    for (int c = 1; c < len; c++) begin
      @(negedge sys_clk);
      if (c == len / 2) ref_clk = 0;
      error_valid = 0;
      error_in = 0;
      if (c >= 10 && c < len - 10) begin
        if (left > 0 && (($urandom % 2) == 1 || left >= len - 10 - c)) begin
          error_valid = 1;
          error_in = ($urandom % 2) == 1 ? 4'h1 : 4'hF;
          left--;
          pend++;
        end else if (($urandom % 2) == 1) error_in = 4'h1;
        else error_valid = 1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    tbl[0]  = '{20, 4, 100, 2, 0};
    tbl[1]  = '{1, 9, 100, 2, 0};
    tbl[2]  = '{1, 8, 100, 2, 0};
    tbl[3]  = '{15, 8, 100, 2, 0};
    tbl[4]  = '{1, 4, 100, 3, 0};
    tbl[5]  = '{15, 4, 100, 3, 0};
    tbl[6]  = '{1, 4, 100, 4, 0};
    tbl[7]  = '{1, 500, 600, 4, 0};
    tbl[8]  = '{2, 500, 600, 4, 0};
    tbl[9]  = '{1, 4, 100, 4, 0};
    tbl[10] = '{1, 500, 600, 4, 0};
    tbl[11] = '{3, 500, 600, 4, 0};
    tbl[12] = '{1, 4, 100, 2, 1};

    repeat (5) @(negedge sys_clk) ref_clk = ~ref_clk;
    #1;
    chk("reset gear", gear, 0);
    chk("reset filter_clr", filter_clr, 0);
    chk("reset locked", locked, 0);
    chk("reset lol_pulse", lol_pulse, 0);
    chk("reset ref_lost", ref_lost, 0);
    chk("reset state", state_out, 0);
    @(negedge sys_clk) rst = 0;
    repeat (10) @(negedge sys_clk) ref_clk = ~ref_clk;
    ref_clk = 0;
    repeat (5) @(negedge sys_clk);
    check_all("idle");

    @(negedge sys_clk) enable = 1;
    model_enable();
    repeat (5) @(negedge sys_clk);
    check_all("enable");

    for (int r = 0; r < 13; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) period(tbl[r].n, tbl[r].len);
      #1;
      chk($sformatf("row%0d state", r), state_out, tbl[r].st);
      chk($sformatf("row%0d gear", r), gear, gmap[tbl[r].st]);
      chk($sformatf("row%0d locked", r), locked, int'(tbl[r].st == 4));
      chk($sformatf("row%0d lol count", r), lol_cnt, tbl[r].lol);
    end

    for (int it = 0; it < 150; it++) begin
      int n = ($urandom % (it < 75 ? 10 : 3)) == 0 ? $urandom_range(9, 14) : $urandom_range(0, 8);
      period(n, $urandom_range(60, 200));
      check_all("rand");
    end

    for (int k = 0; k < 100 && m_st != 4; k++) begin
      period($urandom_range(0, 8), 100);
      check_all("to locked");
    end
    chk("reach locked", state_out, 4);

    repeat (800) @(negedge sys_clk);
    #1;
    chk("no early timeout", ref_lost, 0);
    chk("locked before timeout", state_out, 4);
    w = 0;
    while (ref_lost !== 1'b1 && w < 400) begin
      @(negedge sys_clk);
      w++;
    end
    chk("ref_lost on timeout", ref_lost, 1);
    m_lost = 1; m_st = 2; m_lol++; m_gr = 0; m_br = 0; m_ap = 0; pend = 0;
    repeat (3) @(negedge sys_clk);
    check_all("timeout");
    period(4, 100);
    check_all("ref restart");

    for (int k = 0; k < 100 && !(m_st == 3 && m_gr == 15); k++) begin
      period(4, 100);
      check_all("to track");
    end
    chk("track with 15 good", state_out, 3);
    @(negedge sys_clk) ref_clk = 1;
    @(negedge sys_clk);
    @(negedge sys_clk) enable = 0;
    @(posedge sys_clk) #1;
    chk("drop state", state_out, 0);
    chk("drop gear", gear, 0);
    chk("drop locked", locked, 0);
    m_st = 0; m_gr = 0; m_br = 0; m_ap = 0; pend = 0;
    repeat (50) @(negedge sys_clk);
    ref_clk = 0;
    repeat (50) @(negedge sys_clk);
    check_all("disabled");

    @(negedge sys_clk) enable = 1;
    model_enable();
    repeat (5) @(negedge sys_clk);
    check_all("reenable");
    repeat (5) begin
      period($urandom_range(0, 12), 100);
      check_all("after reenable");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
